// File: rtl/mcs4_pkg.sv
// mcs4_pkg: shared MCS-4 timing constants and the clock-divider run state
package mcs4_pkg;
    localparam logic [2:0] CYC_A1 = 3'd0;
    localparam logic [2:0] CYC_A2 = 3'd1;
    localparam logic [2:0] CYC_A3 = 3'd2;
    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X1 = 3'd5;
    localparam logic [2:0] CYC_X2 = 3'd6;
    localparam logic [2:0] CYC_X3 = 3'd7;
    localparam logic [1:0] SLOT_PHI1 = 2'd0;
    localparam logic [1:0] SLOT_GAP1 = 2'd1;
    localparam logic [1:0] SLOT_PHI2 = 2'd2;
    localparam logic [1:0] SLOT_GAP2 = 2'd3;
    typedef enum logic {ST_STOP, ST_RUN} run_state_t;
endpackage

// File: rtl/mcs4_phase_div.sv
// mcs4_phase_div: div/slot counters with run gating; outputs give the state the next clk will hold
module mcs4_phase_div
    import mcs4_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic [1:0] slot,
    output logic       running,
    output logic       period_start,
    output logic       period_end
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    run_state_t st, st_nx;
    logic [DW-1:0] div, div_nx;
    logic [1:0] slot_q, slot_nx;
    logic last;
    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= ST_STOP;
            div    <= '0;
            slot_q <= SLOT_PHI1;
        end else begin
            st     <= st_nx;
            div    <= div_nx;
            slot_q <= slot_nx;
        end
    end
    // run is only honoured while parked or on the final clk of a period
    always_comb begin
        last    = st == ST_RUN && div == DIV_LAST && slot_q == SLOT_GAP2;
        st_nx   = (st == ST_STOP || last) ? (run ? ST_RUN : ST_STOP) : st;
        div_nx  = (st == ST_STOP || div == DIV_LAST) ? '0 : div + 1'b1;
        slot_nx = st == ST_STOP ? SLOT_PHI1 : div == DIV_LAST ? slot_q + 2'd1 : slot_q;
    end
    always_comb begin
        slot         = slot_nx;
        running      = st_nx == ST_RUN;
        period_start = st_nx == ST_RUN && div_nx == '0 && slot_nx == SLOT_PHI1;
        period_end   = last;
    end
endmodule

// File: rtl/mcs4_cycle_gen.sv
// mcs4_cycle_gen: MCS-4 bus timing master producing PHI1/PHI2, SYNC, cycle index and stretched RESET
module mcs4_cycle_gen
    import mcs4_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int RESET_MCYC = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic       ext_reset_i,
    output logic       PHI1_o,
    output logic       PHI2_o,
    output logic       SYNC_o,
    output logic       RESET_o,
    output logic [2:0] cycle_o,
    output logic       tick_o
);
    localparam int CW = $clog2(RESET_MCYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RESET_MCYC - 1);
    logic [1:0] slot;
    logic running, period_start, period_end, wrap, mcyc_done, reset_nx;
    logic [2:0] cyc_nx;
    logic [CW-1:0] cnt, cnt_nx;
    mcs4_phase_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk          (clk_i),
        .rst          (rst_i),
        .run          (run_i),
        .slot         (slot),
        .running      (running),
        .period_start (period_start),
        .period_end   (period_end)
    );
    // a period end only advances the cycle when the next period actually runs
    always_comb begin
        wrap      = period_end && period_start;
        cyc_nx    = wrap ? cycle_o + 3'd1 : cycle_o;
        mcyc_done = RESET_o && wrap && cycle_o == CYC_X3;
        cnt_nx    = ext_reset_i ? '0 : mcyc_done ? cnt + 1'b1 : cnt;
        reset_nx  = ext_reset_i ? 1'b1 : (mcyc_done && cnt == CNT_LAST) ? 1'b0 : RESET_o;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_o <= CYC_A1;
            cnt     <= '0;
            RESET_o <= 1'b1;
            PHI1_o  <= 1'b0;
            PHI2_o  <= 1'b0;
            SYNC_o  <= 1'b0;
            tick_o  <= 1'b0;
        end else begin
            cycle_o <= cyc_nx;
            cnt     <= cnt_nx;
            RESET_o <= reset_nx;
            PHI1_o  <= running && slot == SLOT_PHI1;
            PHI2_o  <= running && slot == SLOT_PHI2;
            SYNC_o  <= running && cyc_nx == CYC_X3;
            tick_o  <= period_start;
        end
    end
endmodule

// File: tb/tb_mcs4_cycle_gen.sv
// tb_mcs4_cycle_gen: scoreboard bench; stimulus queues per-clk expected outputs, monitor compares at negedge
module tb_mcs4_cycle_gen;
    localparam int D = 2;
    localparam int P = 4 * D;
    typedef struct {
        string      tag;
        logic       phi1;
        logic       phi2;
        logic       sync;
        logic       rst;
        logic       tick;
        logic [2:0] cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_i = 1'b1, run_i = 1'b0, ext_reset_i = 1'b0;
    logic PHI1_o, PHI2_o, SYNC_o, RESET_o, tick_o;
    logic [2:0] cycle_o;
    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int sample = 0;
    mcs4_cycle_gen #(.CLK_DIV(D), .RESET_MCYC(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .run_i       (run_i),
        .ext_reset_i (ext_reset_i),
        .PHI1_o      (PHI1_o),
        .PHI2_o      (PHI2_o),
        .SYNC_o      (SYNC_o),
        .RESET_o     (RESET_o),
        .cycle_o     (cycle_o),
        .tick_o      (tick_o)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        sample++;
        checks++;
        if (PHI1_o && PHI2_o) begin
            failures++;
            $display("FAIL overlap sample %0d: PHI1=%b PHI2=%b required not both high", sample, PHI1_o, PHI2_o);
        end
        if (q.size() != 0) begin
            exp_t e;
            logic [7:0] got, want;
            e = q.pop_front();
            got  = {PHI1_o, PHI2_o, SYNC_o, RESET_o, tick_o, cycle_o};
            want = {e.phi1, e.phi2, e.sync, e.rst, e.tick, e.cyc};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s sample %0d: got phi1/phi2/sync/reset/tick/cyc=%b%b%b%b%b/%0d required %b%b%b%b%b/%0d",
                         e.tag, sample, PHI1_o, PHI2_o, SYNC_o, RESET_o, tick_o, cycle_o,
                         e.phi1, e.phi2, e.sync, e.rst, e.tick, e.cyc);
            end
        end
    end
    task automatic step(input logic r, input logic run, input logic ext, input exp_t e);
        rst_i = r;
        run_i = run;
        ext_reset_i = ext;
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask
    task automatic reset_step(input string tag, input logic ext);
        exp_t e;
        e = '{tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        step(1'b1, 1'b1, ext, e);
    endtask
    task automatic period(input string tag, input logic [2:0] c, input logic r0, input logic r1,
                          input int ext_k, input int stop_k, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.tag  = tag;
            e.phi1 = k < D;
            e.phi2 = k >= 2 * D && k < 3 * D;
            e.sync = c == 3'd7;
            e.rst  = k < ext_k ? r0 : r1;
            e.tick = k == 0;
            e.cyc  = c;
            step(1'b0, k < stop_k, k == ext_k, e);
        end
    endtask
    task automatic stopped(input logic [2:0] c, input logic r);
        exp_t e;
        e = '{"stopped", 1'b0, 1'b0, 1'b0, r, 1'b0, c};
        step(1'b0, 1'b0, 1'b0, e);
    endtask
    initial begin
        repeat (3) reset_step("reset", 1'b0);
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 8; c++) period("stretch", 3'(c), 1'b1, 1'b1, P, P, P);
        period("release", 3'd0, 1'b0, 1'b0, P, P, P);
        for (int c = 1; c < 4; c++) period("run", 3'(c), 1'b0, 1'b0, P, P, P);
        period("ext_m2", 3'd4, 1'b0, 1'b1, 3, P, P);
        for (int c = 5; c < 8; c++) period("ext_hold", 3'(c), 1'b1, 1'b1, P, P, P);
        for (int c = 0; c < 8; c++) period("ext_hold", 3'(c), 1'b1, 1'b1, P, P, P);
        period("ext_release", 3'd0, 1'b0, 1'b0, P, P, P);
        for (int c = 1; c < 5; c++) period("run", 3'(c), 1'b0, 1'b0, P, P, P);
        period("stop_x1", 3'd5, 1'b0, 1'b0, P, 4, P);
        repeat (3) stopped(3'd5, 1'b0);
        period("restart", 3'd5, 1'b0, 1'b0, P, P, P);
        period("after_restart", 3'd6, 1'b0, 1'b0, P, P, P);
        period("after_restart", 3'd7, 1'b0, 1'b0, P, P, P);
        period("after_restart", 3'd0, 1'b0, 1'b0, P, P, P);
        period("pre_mrst", 3'd1, 1'b0, 1'b0, P, P, 3);
        repeat (2) reset_step("mid_reset", 1'b1);
        period("post_mrst", 3'd0, 1'b1, 1'b1, P, P, P);
        period("post_mrst", 3'd1, 1'b1, 1'b1, P, P, P);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected samples left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
